mac_lane_array: RTL and testbench
=================================

# mac_lane_array

Parametrised multiply-accumulate engine for the convolution datapath. It computes `LANES` parallel unsigned dot products of `TAPS` terms each, repeated for `GROUPS` output groups per job. Coefficients come in pairs from the coefficient ROM; input samples come from the row-buffer shift registers. Each finished group of lane results is handed to the result memory writer over a single-entry valid/ready output register with backpressure.

## Interface
Parameters:
- `LANES`, 4: parallel rows, one accumulator each.
- `X_W`, 8: sample width.
- `C_W`, 7: coefficient width.
- `TAPS`, 8: products per result; must be even, at least 2.
- `GROUPS`, 4: result groups per job.
- `OUT_W`, 16: result width per lane.
- Derived: `ACC_W = X_W + C_W + clog2(TAPS)`; `RA_W = clog2(GROUPS*TAPS/2)`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: job request, sampled in IDLE only.
- `coef_pair` in `2*C_W`: ROM word at `rom_addr`. Upper half is used on even taps, lower half on odd taps. The ROM is asynchronous.
- `x_in` in `LANES*X_W`: current head sample of each row; lane 0 is in the LSBs.
- `x_shift` out 1: consume `x_in`; the row buffers advance on this edge.
- `rom_addr` out `RA_W`: coefficient word index.
- `tap_idx` out `clog2(TAPS)`: current tap.
- `res_valid` out 1: result register holds data.
- `res_ready` in 1: consumer accepts when `res_valid` and `res_ready` are both high.
- `res_data` out `LANES*OUT_W`: lane results; lane 0 is in the LSBs.
- `done` out 1: one-cycle pulse at job end.

## Operation
States:
- **IDLE**
  - `start` moves to RUN and clears the accumulators, `tap_idx`, the group counter and `rom_addr`.
- **RUN**
  - When not stalled, each cycle:
    - `acc[l] += coef * x_in[l]`, where `coef = tap_idx` even ? `coef_pair[2*C_W-1:C_W]` : `coef_pair[C_W-1:0]`.
    - `tap_idx` increments.
    - After an odd tap, `rom_addr` increments, wrapping at `2^RA_W`.
  - On the last tap (`tap_idx == TAPS-1`), the final sum including this tap goes into the result register and `res_valid` is set.
    - The accumulators clear, `tap_idx` returns to 0 and the group counter increments.
    - After group `GROUPS-1`, the state moves to FLUSH.
  - Stall: the last tap is due while `res_valid && !res_ready`.
    - No accumulate, counters hold, `x_shift` is 0.
  - If `res_ready` is high in the same cycle as the last tap, the old result is accepted and the new one is loaded. There is no stall and no bubble.
- **FLUSH**
  - Waits until `res_valid` is 0, or `res_valid && res_ready`.
  - Then sets `done` for one cycle and moves to IDLE.

General rules:
- `x_shift` equals (state == RUN && !stall), combinationally from state.
- `start` outside IDLE is ignored.
- `res_valid` clears on acceptance when no new result is loaded.
- `res_data` holds stable while `res_valid && !res_ready`.
- Arithmetic is fully unsigned. The accumulator is `ACC_W` bits wide and can never overflow.
- Reset mid-job returns to IDLE immediately with all outputs 0. No partial result is emitted.

## Timing
- Reset values: `x_shift`, `rom_addr`, `tap_idx`, `res_valid`, `res_data`, `done` are all 0; state is IDLE.
- `start` sampled at edge E0. Taps accumulate on edges E1..E(TAPS·GROUPS).
- The first `res_valid` is high after edge E_TAPS.
- With `res_ready` tied high:
  - the last result is accepted at E(TAPS·GROUPS+1);
  - `done` is high for the cycle after that edge;
  - IDLE is reached after E(TAPS·GROUPS+2).
- Each stall cycle delays every later event by one cycle.
- Sample and coefficient for a tap must be valid in the cycle before that tap's accumulate edge.

## Configuration
- `MAC_LANE_ARRAY_SAT_EN` defined: each lane result clamps to `2^OUT_W-1` when `acc >= 2^OUT_W`.
- Not defined: each lane result is `acc[OUT_W-1:0]` (truncation).

## Structure
- Shared package `mac_pkg`:
  - the state enum (IDLE, RUN, FLUSH);
  - `ACC_W` and `RA_W` width functions;
  - the default parameter constants.
- One sub-module, `mac_lane`:
  - one accumulator with multiply-add, clear, enable;
  - output formatting (saturate or truncate per the macro);
  - instantiated `LANES` times by a generate loop.

## Test plan
All scenarios use the defaults.
- Smoke: all coefficients 1, all samples 1, `res_ready`=1 → four results, each lane = 8; `done` high in the cycle after E33.
- Max value: coefficients 127, samples 255 → `acc` = 259080. With the macro, `res_data` lane = 65535; without it, lane = 62472.
- Backpressure: `res_ready`=0 during cycles 9–20 → `x_shift`=0 during the stall, `res_data` stays stable, no tap lost, results identical to the no-stall run.
- ROM ordering: `coef_pair` = {addr+1, addr+2}, samples 1 → each group sum = Σ over that group's four words of (2·addr+3), e.g. group 0 = 24; `rom_addr` sequence matches.
- Reset at cycle 12 of RUN → all outputs 0 next cycle, no `done`; a new `start` gives correct results.
- `start` pulsed during RUN → ignored; exactly one `done` per job.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the mac_lane_array convolution MAC engine.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DEF_LANES  = 4;
  localparam int DEF_X_W    = 8;
  localparam int DEF_C_W    = 7;
  localparam int DEF_TAPS   = 8;
  localparam int DEF_GROUPS = 4;
  localparam int DEF_OUT_W  = 16;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int x_w, input int c_w, input int taps);
    return x_w + c_w + $clog2(taps);
  endfunction

  function automatic int ra_w(input int groups, input int taps);
    return cnt_w(groups * taps / 2);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: accumulator plus result formatting.
// MAC_LANE_ARRAY_SAT_EN selects saturation instead of truncation of the lane result.
module mac_lane
  import mac_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int C_W   = DEF_C_W,
  parameter int ACC_W = acc_w(DEF_X_W, DEF_C_W, DEF_TAPS),
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             last,
  input  logic [C_W-1:0]   coef,
  input  logic [X_W-1:0]   x,
  output logic [OUT_W-1:0] res
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;

  // Sum including the current tap; the result register captures it on the last tap.
  assign sum_s = acc_r + (ACC_W'(coef) * ACC_W'(x));

  // Accumulator: cleared at job start and after each group's last tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
    end else if (clr || (en && last)) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum_s;
    end
  end

  generate
    if (ACC_W > OUT_W) begin : g_wide
`ifdef MAC_LANE_ARRAY_SAT_EN
      assign res = (|sum_s[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : sum_s[OUT_W-1:0];
`else
      assign res = sum_s[OUT_W-1:0];
`endif
    end else begin : g_narrow
      assign res = OUT_W'(sum_s);
    end
  endgenerate

endmodule

// File: rtl/mac_lane_array.sv
// LANES parallel unsigned dot products over TAPS taps, GROUPS results per job,
// with a single-entry valid/ready result register. Optional macro: MAC_LANE_ARRAY_SAT_EN.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int X_W    = DEF_X_W,
  parameter int C_W    = DEF_C_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int GROUPS = DEF_GROUPS,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [2*C_W-1:0]                coef_pair,
  input  logic [LANES*X_W-1:0]            x_in,
  output logic                            x_shift,
  output logic [ra_w(GROUPS, TAPS)-1:0]   rom_addr,
  output logic [cnt_w(TAPS)-1:0]          tap_idx,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [LANES*OUT_W-1:0]          res_data,
  output logic                            done
);

  localparam int ACC_W = acc_w(X_W, C_W, TAPS);
  localparam int RA_W  = ra_w(GROUPS, TAPS);
  localparam int TI_W  = cnt_w(TAPS);
  localparam int G_W   = cnt_w(GROUPS);

  state_t                   state_r, state_nxt_s;
  logic [TI_W-1:0]          tap_r;
  logic [G_W-1:0]           grp_r;
  logic [RA_W-1:0]          rom_addr_r;
  logic                     res_valid_r;
  logic [LANES*OUT_W-1:0]   res_data_r;
  logic                     done_r, done_nxt_s;
  logic [LANES*OUT_W-1:0]   lane_res_s;
  logic [C_W-1:0]           coef_s;
  logic                     start_s, last_tap_s, last_grp_s;
  logic                     stall_s, adv_s, load_s, accept_s;

  assign start_s    = (state_r == ST_IDLE) && start;
  assign last_tap_s = (tap_r == TI_W'(TAPS - 1));
  assign last_grp_s = (grp_r == G_W'(GROUPS - 1));
  assign accept_s   = res_valid_r && res_ready;
  assign stall_s    = (state_r == ST_RUN) && last_tap_s && res_valid_r && !res_ready;
  assign adv_s      = (state_r == ST_RUN) && !stall_s;
  assign load_s     = adv_s && last_tap_s;
  assign coef_s     = tap_r[0] ? coef_pair[C_W-1:0] : coef_pair[2*C_W-1:C_W];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; FLUSH raises done once, then drops to IDLE on the following edge.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (load_s && last_grp_s) state_nxt_s = ST_FLUSH;
        else                      state_nxt_s = ST_RUN;
      end
      ST_FLUSH: begin
        if (done_r) begin
          state_nxt_s = ST_IDLE;
        end else if (!res_valid_r || res_ready) begin
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Tap, group and ROM address counters plus the result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_r       <= '0;
      grp_r       <= '0;
      rom_addr_r  <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= done_nxt_s;
      if (start_s) begin
        tap_r      <= '0;
        grp_r      <= '0;
        rom_addr_r <= '0;
      end else if (adv_s) begin
        tap_r <= last_tap_s ? '0 : tap_r + TI_W'(1);
        if (tap_r[0]) rom_addr_r <= rom_addr_r + RA_W'(1);
        if (last_tap_s) grp_r <= last_grp_s ? '0 : grp_r + G_W'(1);
      end
      if (load_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= lane_res_s;
      end else if (accept_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      mac_lane #(
        .X_W  (X_W),
        .C_W  (C_W),
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (start_s),
        .en  (adv_s),
        .last(last_tap_s),
        .coef(coef_s),
        .x   (x_in[l*X_W +: X_W]),
        .res (lane_res_s[l*OUT_W +: OUT_W])
      );
    end
  endgenerate

  assign x_shift   = adv_s;
  assign rom_addr  = rom_addr_r;
  assign tap_idx   = tap_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard bench for mac_lane_array: randomized jobs checked against a dot-product model.
module tb_mac_lane_array;

  localparam int LANES = 4, X_W = 8, C_W = 7, TAPS = 8, GROUPS = 4, OUT_W = 16;
  localparam int NS = TAPS * GROUPS;
  localparam int NW = NS / 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic                   res_ready = 1'b0;
  logic [2*C_W-1:0]       coef_pair;
  logic [LANES*X_W-1:0]   x_in;
  logic                   x_shift;
  logic [3:0]             rom_addr;
  logic [2:0]             tap_idx;
  logic                   res_valid;
  logic [LANES*OUT_W-1:0] res_data;
  logic                   done;

  mac_lane_array #(
    .LANES(LANES), .X_W(X_W), .C_W(C_W), .TAPS(TAPS), .GROUPS(GROUPS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .coef_pair(coef_pair), .x_in(x_in),
    .x_shift(x_shift), .rom_addr(rom_addr), .tap_idx(tap_idx), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .done(done)
  );

  always #5 clk = ~clk;

  int               smp [LANES][NS];
  logic [2*C_W-1:0] rom_mem [NW];
  int               cmode = 0;
  int               shift_cnt = 0;
  int               cyc = 0;
  bit               cnt_clr = 1'b0;
  bit               job_active = 1'b0;
  bit               chk_timing = 1'b0;
  int               done_cnt = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [63:0]      exp_q [$];
  logic [63:0]      exp_v;
  bit               hold_r = 1'b0;
  logic [63:0]      hold_data;

  // Asynchronous coefficient ROM contents, selected per job.
  function automatic logic [2*C_W-1:0] word_of(input int cm, input int a);
    case (cm)
      0:       return {7'd1, 7'd1};
      1:       return {7'd127, 7'd127};
      2:       return {7'(a + 1), 7'(a + 2)};
      default: return rom_mem[a % NW];
    endcase
  endfunction

  always_comb begin
    case (cmode)
      0:       coef_pair = {7'd1, 7'd1};
      1:       coef_pair = {7'd127, 7'd127};
      2:       coef_pair = {7'(rom_addr + 4'd1), 7'(rom_addr + 4'd2)};
      default: coef_pair = rom_mem[rom_addr];
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      x_in[l*X_W +: X_W] = X_W'(smp[l][(shift_cnt < NS) ? shift_cnt : NS - 1]);
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      shift_cnt <= 0;
      cyc       <= 0;
    end else begin
      cyc <= cyc + 1;
      if (x_shift && rst) shift_cnt <= shift_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x_shift"},   64'(x_shift),   64'd0);
    chk({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
    chk({tag, "_tap_idx"},   64'(tap_idx),   64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"},  res_data,       64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  // Model: each group is a plain dot product of its TAPS samples and coefficients.
  task automatic push_expected(input int cm);
    logic [63:0] vec;
    logic [2*C_W-1:0] w;
    int acc, c, r;
    for (int g = 0; g < GROUPS; g++) begin
      vec = '0;
      for (int l = 0; l < LANES; l++) begin
        acc = 0;
        for (int t = 0; t < TAPS; t++) begin
          w = word_of(cm, (g * TAPS + t) / 2);
          c = (t % 2 == 0) ? int'(w[2*C_W-1:C_W]) : int'(w[C_W-1:0]);
          acc += c * smp[l][g * TAPS + t];
        end
`ifdef MAC_LANE_ARRAY_SAT_EN
        r = (acc > 65535) ? 65535 : acc;
`else
        r = acc % 65536;
`endif
        vec[l*OUT_W +: OUT_W] = 16'(r);
      end
      exp_q.push_back(vec);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the per-cycle contract.
  always @(negedge clk) begin
    if (rst) begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
        end else begin
          exp_v = exp_q.pop_front();
          chk("res_data", res_data, exp_v);
        end
      end
      if (hold_r) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", res_data, hold_data);
      end
      hold_r    = res_valid && !res_ready;
      hold_data = res_data;
      if (done) begin
        done_cnt++;
        if (chk_timing) chk("done_cycle", 64'(cyc), 64'(NS + 1));
      end
      if (job_active) begin
        if (shift_cnt < NS) begin
          chk("tap_idx", 64'(tap_idx), 64'(shift_cnt % TAPS));
          chk("rom_addr", 64'(rom_addr), 64'((shift_cnt / 2) % NW));
          chk("x_shift", 64'(x_shift),
              64'(!((shift_cnt % TAPS == TAPS - 1) && res_valid && !res_ready)));
        end else begin
          chk("x_shift_end", 64'(x_shift), 64'd0);
        end
      end
    end else begin
      hold_r = 1'b0;
    end
  end

  // One job: cm = coefficient/sample mode, rm = ready profile, rst_at = RUN cycle to reset at.
  task automatic run_job(input int cm, input int rm, input bit chk_t, input bit mid_start,
                         input int rst_at);
    bit finished = 1'b0;
    cmode = cm;
    for (int a = 0; a < NW; a++) rom_mem[a] = 14'($urandom);
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < NS; s++)
        smp[l][s] = (cm == 1) ? 255 : ((cm == 3) ? int'($urandom_range(0, 255)) : 1);
    push_expected(cm);
    @(posedge clk); #1;
    start = 1'b1; cnt_clr = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cnt_clr = 1'b0;
    done_cnt = 0; chk_timing = chk_t; job_active = 1'b1;
    for (int k = 0; k < 400 && !finished; k++) begin
      case (rm)
        1:       res_ready = !(cyc >= 8 && cyc <= 19);
        2:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b1;
      endcase
      start = mid_start && (cyc == 5 || cyc == 6);
      if (rst_at > 0 && cyc == rst_at) begin
        rst = 1'b0;
        job_active = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("done_after_reset", 64'(done_cnt), 64'd0);
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (done_cnt > 0) finished = 1'b1;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_timeout: got no done expected done within 400 cycles");
    end
    start = 1'b0;
    if (rst_at == 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
    end
    job_active = 1'b0;
    chk_timing = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(0, 0, 1'b1, 1'b0, 0);   // smoke: each lane = 8, done after E33
    run_job(1, 0, 1'b0, 1'b0, 0);   // max value: 259080 saturated or truncated
    run_job(3, 1, 1'b0, 1'b0, 0);   // backpressure window forcing a stall
    run_job(2, 0, 1'b0, 1'b0, 0);   // ROM ordering, group 0 = 24
    run_job(3, 0, 1'b0, 1'b0, 12);  // reset mid-job
    run_job(3, 0, 1'b0, 1'b0, 0);   // restart after reset
    run_job(3, 0, 1'b0, 1'b1, 0);   // start pulsed during RUN
    for (int j = 0; j < 3; j++) run_job(3, 2, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
